// File: rtl/mux_scan_sampler_if.sv
// Frame delivery channel from the scan sampler to its downstream consumer.
interface mux_scan_sampler_if;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;

  modport master (
    output frame,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// Scans the enabled channels of an external 8:1 mux and packs the sampled bits into one frame.
// Latency: 1 + popcount(mask)*(SETTLE+1) edges from accepting start to frame_valid.
// Backpressure: the frame is held stable in HOLD until frame_ready; start is ignored outside IDLE.
module mux_scan_sampler #(
  parameter int SETTLE = 1,
  parameter int CW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          mask,
  input  logic                mux_x,
  output logic [2:0]          sel,
  output logic                busy,
  mux_scan_sampler_if.master  frm
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  // With no settle time a new channel goes straight to its sample cycle.
  localparam state_t          SCAN_ENTRY  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    mask_q;
  logic [7:0]    shadow;
  logic [7:0]    frame_q;
  logic          frame_valid_q;

  logic [3:0]    first_ch;
  logic [3:0]    next_ch;
  logic [7:0]    shadow_n;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] lowest_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  assign first_ch = lowest_from(mask, 4'd0);
  assign next_ch  = lowest_from(mask_q, {1'b0, sel} + 4'd1);
  assign shadow_n = shadow | (8'(mux_x) << sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel           <= 3'd0;
      cnt           <= '0;
      mask_q        <= 8'h00;
      shadow        <= 8'h00;
      frame_q       <= 8'h00;
      frame_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q <= mask;
            shadow <= 8'h00;
            cnt    <= '0;
            if (first_ch[3]) begin
              sel   <= first_ch[2:0];
              state <= SCAN_ENTRY;
            end else begin
              frame_q       <= 8'h00;
              frame_valid_q <= 1'b1;
              state         <= ST_HOLD;
            end
          end
        end

        ST_SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          shadow <= shadow_n;
          if (next_ch[3]) begin
            sel   <= next_ch[2:0];
            cnt   <= '0;
            state <= SCAN_ENTRY;
          end else begin
            frame_q       <= shadow_n;
            frame_valid_q <= 1'b1;
            state         <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (frame_valid_q && frm.frame_ready) begin
            frame_valid_q <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = (state != ST_IDLE);
  assign frm.frame       = frame_q;
  assign frm.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: one instance with SETTLE=1, one with SETTLE=0, each driving a modelled 8:1 mux.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] start = 2'b00;
  logic [7:0] mask_in = 8'h00;
  logic [7:0] dat [2];
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic       mux_a, mux_b;

  mux_scan_sampler_if if_a ();
  mux_scan_sampler_if if_b ();

  assign mux_a = dat[0][sel_a];
  assign mux_b = dat[1][sel_b];

  mux_scan_sampler #(.SETTLE(1), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .mask(mask_in), .mux_x(mux_a),
    .sel(sel_a), .busy(busy_a), .frm(if_a)
  );

  mux_scan_sampler #(.SETTLE(0), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .mask(mask_in), .mux_x(mux_b),
    .sel(sel_b), .busy(busy_b), .frm(if_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit         cur = 1'b0;
  logic [2:0] c_sel;
  logic       c_busy, c_fv;
  logic [7:0] c_frame;
  assign c_sel   = cur ? sel_b : sel_a;
  assign c_busy  = cur ? busy_b : busy_a;
  assign c_fv    = cur ? if_b.frame_valid : if_a.frame_valid;
  assign c_frame = cur ? if_b.frame : if_a.frame;

  typedef struct {
    bit         d;
    logic [7:0] m;
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_frame;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rdy(input bit d, input logic v);
    if (d) if_b.frame_ready = v;
    else   if_a.frame_ready = v;
  endtask

  task automatic scan(input bit d, input logic [7:0] m, input logic [7:0] data, input int hold,
                      input logic [7:0] ef, input int el, input string tag);
    int         lat;
    int         nvis;
    int         nev;
    logic [23:0] vis;
    logic [23:0] evis;
    logic [2:0] last;
    bit         ok;
    cur = d;
    @(negedge clk);
    mask_in  = m;
    dat[d]   = data;
    start[d] = 1'b1;
    set_rdy(d, hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start[d] = 1'b0;
    mask_in  = 8'($urandom);
    check({tag, "_busy"}, 32'(c_busy), 32'd1);
    nvis = 0;
    vis  = '0;
    last = '0;
    while (!c_fv && lat < 400) begin
      if (nvis == 0 || c_sel != last) begin
        vis  = {vis[20:0], c_sel};
        last = c_sel;
        nvis++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    evis = '0;
    nev  = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        evis = {evis[20:0], 3'(i)};
        nev++;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_frame"}, 32'(c_frame), 32'(ef));
    check({tag, "_nvisit"}, 32'(nvis), 32'(nev));
    check({tag, "_visits"}, 32'(vis), 32'(evis));
    if (hold > 0) begin
      ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        start[d] = (k == hold / 2);
        @(posedge clk);
        @(negedge clk);
        if (!c_fv || c_frame !== ef || !c_busy) ok = 1'b0;
      end
      start[d] = 1'b0;
      check({tag, "_hold_stable"}, 32'(ok), 32'd1);
      set_rdy(d, 1'b1);
      start[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    set_rdy(d, 1'b0);
    check({tag, "_handshake"}, {30'd0, c_fv, c_busy}, 32'd0);
    check({tag, "_frame_kept"}, 32'(c_frame), 32'(ef));
  endtask

  vec_t vecs [8];

  initial begin
    int         n;
    bit         d;
    logic [7:0] m;
    logic [7:0] data;

    vecs[0] = '{1'b0, 8'hFF, 8'hA6, 0, 8'hA6, 17};
    vecs[1] = '{1'b0, 8'h81, 8'hFF, 0, 8'h81, 5};
    vecs[2] = '{1'b0, 8'hFF, 8'h5C, 10, 8'h5C, 17};
    vecs[3] = '{1'b0, 8'h00, 8'h5A, 0, 8'h00, 1};
    vecs[4] = '{1'b1, 8'hFF, 8'h3C, 0, 8'h3C, 9};
    vecs[5] = '{1'b1, 8'h81, 8'hFF, 2, 8'h81, 3};
    vecs[6] = '{1'b0, 8'h0F, 8'hF5, 3, 8'h05, 9};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 1, 8'h00, 1};

    dat[0] = 8'h00;
    dat[1] = 8'h00;
    if_a.frame_ready = 1'b0;
    if_b.frame_ready = 1'b0;

    // Reset and idle hold.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_a", {18'd0, sel_a, busy_a, if_a.frame_valid, if_a.frame}, 32'd0);
      check("reset_b", {18'd0, sel_b, busy_b, if_b.frame_valid, if_b.frame}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      scan(vecs[i].d, vecs[i].m, vecs[i].data, vecs[i].hold,
           vecs[i].exp_frame, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Reset while the SETTLE=1 instance is settling on channel 3.
    cur = 1'b0;
    @(negedge clk);
    mask_in  = 8'hFF;
    dat[0]   = 8'h5A;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (sel_a != 3'd3 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("midrst_reach_sel3", 32'(n < 50), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", {20'd0, sel_a, busy_a, if_a.frame_valid, if_a.frame}, 32'd0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (if_a.frame_valid || busy_a) n++;
    end
    check("midrst_no_frame", 32'(n), 32'd0);
    scan(1'b0, 8'hFF, 8'hC3, 0, 8'hC3, 17, "post_rst");

    // Random scans against the reference rules.
    for (int r = 0; r < 20; r++) begin
      d    = 1'($urandom_range(0, 1));
      m    = 8'($urandom);
      data = 8'($urandom);
      if (r % 5 == 0) m = 8'h00;
      scan(d, m, data, $urandom_range(0, 3), data & m,
           1 + $countones(m) * (d ? 1 : 2), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Sequential front-end controller for the 8:1 select mux.
- Drives the mux select lines `sel[2:0]` and samples the single-bit mux output `mux_x`.
- Scans every enabled channel in one pass and assembles the results into an 8-bit frame.
- Delivers the frame downstream over a valid/ready handshake; turns the combinational mux into a scanned 8-channel bit sampler.

Parameters:
- SETTLE, default 1: wait cycles after `sel` changes before sampling. Range 0..15.
- CW, default 4: width of the internal settle counter. Must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  scan request; accepted only in IDLE.
- mask  input  8  channel enable; bit i=1 means scan channel i. Latched when start is accepted.
- mux_x  input  1  output of the 8:1 mux.
- sel  output  3  mux select; drives s[2:0] of the mux.
- busy  output  1  high whenever state != IDLE.
- frame  output  8  assembled sample frame; bit i holds channel i.
- frame_valid  output  1  frame available.
- frame_ready  input  1  downstream accepts frame.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high, sampled only on the rising edge of `clk`.
- Reset values: sel=0, busy=0, frame=8'h00, frame_valid=0, state=IDLE, latched mask=0, shadow register=0, settle counter=0.
- Reset asserted mid-scan or in HOLD aborts immediately. The pending frame is discarded with no handshake.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - On start=1, latch mask and clear the 8-bit shadow register.
  - If latched mask != 0: go to SETTLE, set sel to the lowest enabled channel, and clear the settle counter.
  - If mask == 0: go directly to HOLD with frame=8'h00.
- SETTLE: the counter increments each cycle. When the counter reaches SETTLE, go to SAMPLE. If SETTLE=0, skip SETTLE entirely and enter SAMPLE straight from IDLE or the previous SAMPLE.
- SAMPLE (exactly one cycle): the edge leaving SAMPLE writes mux_x into shadow[sel].
  - If a higher-numbered enabled channel remains, sel jumps to the next enabled index (disabled channels are skipped, never visited), the counter clears, and the state returns to SETTLE (or SAMPLE if SETTLE=0).
  - Otherwise: frame <= shadow with the last bit included, frame_valid <= 1, go to HOLD.
- HOLD:
  - frame and frame_valid stay stable while frame_ready=0.
  - On an edge with frame_valid & frame_ready, clear frame_valid and go to IDLE.
  - frame keeps its value in IDLE until the next frame overwrites it.
- Disabled channel bits in frame are always 0.
- sel holds its last value in IDLE and HOLD. sel changes only on the edge entering SETTLE/SAMPLE for a new channel.
- start is ignored in every state except IDLE, including HOLD and the handshake cycle. Re-arming requires start high on a cycle when state is IDLE.
- Latency from the edge that accepts start to the edge raising frame_valid: 1 + N_en*(SETTLE+1) cycles, where N_en = popcount(latched mask). With mask=0 this is 1 cycle.
- Changes to mask input during a scan have no effect.
- mux_x must be stable for the SAMPLE cycle. The block adds no synchroniser; mux_x is assumed to come from the same clock domain.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release with start=0 -> sel=0, frame=8'h00, frame_valid=0, busy=0, all held.
- Full scan: SETTLE=1, mask=8'hFF, mux inputs d7..d0=8'b1010_0110, frame_ready=1 -> frame_valid rises exactly 17 edges after start is accepted, frame=8'hA6, valid for 1 cycle, back to IDLE.
- Sparse mask: mask=8'h81, data 8'hFF, SETTLE=1 -> sel visits only 0 then 7, frame=8'h81, latency 5 cycles.
- Backpressure: frame_ready=0 for 10 cycles after valid -> frame and frame_valid stable; a start pulse during HOLD is ignored; frame_ready=1 completes the handshake; next start begins a fresh scan.
- Empty mask and SETTLE=0: mask=8'h00 -> frame=8'h00 valid 1 cycle after start; with SETTLE=0 and mask=8'hFF -> latency 9 cycles, correct data.
- Reset mid-scan: assert rst while sel=3 in SETTLE -> next edge sel=0, busy=0, frame_valid=0, no frame emitted; a subsequent scan is correct.
